// File: rtl/wb_port_arbiter.sv
// Register-file writeback arbiter: merges pipeline channel A with a 2-entry buffered channel B.
// Optional define WB_FWD_EN adds combinational forwarding lookups over the output register and FIFO.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   output logic        RegWrite,
   output logic [4:0]  Rd,
   output logic [31:0] data,
   output logic [1:0]  pend_cnt,
`ifdef WB_FWD_EN
   input  logic [4:0]  fwd_rs,
   input  logic [4:0]  fwd_rt,
   output logic        fwd_rs_hit,
   output logic        fwd_rt_hit,
   output logic [31:0] fwd_rs_data,
   output logic [31:0] fwd_rt_data,
`endif
   output logic        busy
);

   localparam int unsigned RD_W   = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 3;

   typedef struct packed {
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } wbEntry_t;

   wbEntry_t         fifoMem [2];
   logic             wrPtr;
   logic             rdPtr;
   logic [1:0]       pendCnt;
   logic [CNT_W-1:0] starveCnt;

   logic fifoFull;
   logic fifoEmpty;
   logic starveHit;
   logic selA;
   logic selB;
   logic enq;

   assign fifoFull  = (pendCnt == 2'd2);
   assign fifoEmpty = (pendCnt == 2'd0);
   assign starveHit = !fifoEmpty && (starveCnt >= CNT_W'(STARVE_LIM));

   // Handshakes depend only on registered state.
   assign a_ready  = !starveHit;
   assign b_ready  = !fifoFull;
   assign busy     = !fifoEmpty;
   assign pend_cnt = pendCnt;

   // One write per cycle: starved head, then A, then any buffered head.
   always_comb begin
      selA = 1'b0;
      selB = 1'b0;
      enq  = 1'b0;
      if (starveHit) begin
         selB = 1'b1;
      end else if (a_valid) begin
         selA = 1'b1;
      end else if (!fifoEmpty) begin
         selB = 1'b1;
      end
      // rd 0 is acknowledged but never buffered.
      enq = b_valid && !fifoFull && (b_rd != RD_W'(0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fifoMem[0] <= '0;
         fifoMem[1] <= '0;
         wrPtr      <= 1'b0;
         rdPtr      <= 1'b0;
         pendCnt    <= 2'd0;
         starveCnt  <= '0;
         RegWrite   <= 1'b0;
         Rd         <= '0;
         data       <= '0;
      end else begin
         if (enq) begin
            fifoMem[wrPtr] <= '{rd: b_rd, data: b_data};
            wrPtr          <= ~wrPtr;
         end
         if (selB) begin
            rdPtr <= ~rdPtr;
         end
         pendCnt <= pendCnt + 2'(enq) - 2'(selB);

         if (fifoEmpty || selB) begin
            starveCnt <= '0;
         end else if (starveCnt < CNT_W'(STARVE_LIM)) begin
            starveCnt <= starveCnt + CNT_W'(1);
         end

         // Rd/data hold their last values unless a real write is issued.
         if (selA) begin
            RegWrite <= (a_rd != RD_W'(0));
            if (a_rd != RD_W'(0)) begin
               Rd   <= a_rd;
               data <= a_data;
            end
         end else if (selB) begin
            RegWrite <= 1'b1;
            Rd       <= fifoMem[rdPtr].rd;
            data     <= fifoMem[rdPtr].data;
         end else begin
            RegWrite <= 1'b0;
         end
      end
   end

`ifdef WB_FWD_EN
   // Newest value wins: output register, then youngest FIFO entry, then oldest.
   function automatic logic [DATA_W:0] fwdLookup(input logic [RD_W-1:0] rs);
      logic [DATA_W:0] res;
      res = '0;
      if (rs != RD_W'(0)) begin
         if (RegWrite && (Rd == rs)) begin
            res = {1'b1, data};
         end else if (!fifoEmpty && (fifoMem[~wrPtr].rd == rs)) begin
            res = {1'b1, fifoMem[~wrPtr].data};
         end else if (fifoFull && (fifoMem[rdPtr].rd == rs)) begin
            res = {1'b1, fifoMem[rdPtr].data};
         end
      end
      return res;
   endfunction

   assign {fwd_rs_hit, fwd_rs_data} = fwdLookup(fwd_rs);
   assign {fwd_rt_hit, fwd_rt_data} = fwdLookup(fwd_rt);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations (STARVE_LIM = 4).
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, a_ready;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        b_valid, b_ready;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        RegWrite;
   logic [4:0]  Rd;
   logic [31:0] data;
   logic [1:0]  pend_cnt;
   logic        busy;
`ifdef WB_FWD_EN
   logic [4:0]  fwd_rs, fwd_rt;
   logic        fwd_rs_hit, fwd_rt_hit;
   logic [31:0] fwd_rs_data, fwd_rt_data;
   assign fwd_rs = 5'd0;
   assign fwd_rt = 5'd0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.STARVE_LIM(4)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .RegWrite(RegWrite), .Rd(Rd), .data(data), .pend_cnt(pend_cnt),
`ifdef WB_FWD_EN
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
      .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
`endif
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_rd", 32'(Rd), 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_pend", 32'(pend_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_a_ready", 32'(a_ready), 32'd1);
      chk("rst_b_ready", 32'(b_ready), 32'd1);

      // A only
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
      tick();
      a_valid = 1'b0;
      chk("a_only_we", 32'(RegWrite), 32'd1);
      chk("a_only_rd", 32'(Rd), 32'd5);
      chk("a_only_data", data, 32'h1234);
      tick();
      chk("idle_we", 32'(RegWrite), 32'd0);
      chk("idle_rd_hold", 32'(Rd), 32'd5);
      chk("idle_data_hold", data, 32'h1234);

      // A and B together: A first, B next cycle
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAAAA;
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hBBBB;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      chk("ab_a_rd", 32'(Rd), 32'd3);
      chk("ab_a_data", data, 32'hAAAA);
      chk("ab_pend1", 32'(pend_cnt), 32'd1);
      chk("ab_busy", 32'(busy), 32'd1);
      tick();
      chk("ab_b_we", 32'(RegWrite), 32'd1);
      chk("ab_b_rd", 32'(Rd), 32'd7);
      chk("ab_b_data", data, 32'hBBBB);
      chk("ab_pend0", 32'(pend_cnt), 32'd0);
      tick();

      // Starvation: A every cycle, one B entry
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'd0;
      b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999;
      tick();
      b_valid = 1'b0;
      chk("st_enq_pend", 32'(pend_cnt), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("st_a_ready_hi", 32'(a_ready), 32'd1);
         a_data = 32'(i);
         tick();
         chk("st_a_rd", 32'(Rd), 32'd1);
         chk("st_a_data", data, 32'(i));
      end
      chk("st_a_ready_lo", 32'(a_ready), 32'd0);
      tick();
      chk("st_b_rd", 32'(Rd), 32'd9);
      chk("st_b_data", data, 32'h9999);
      chk("st_pend0", 32'(pend_cnt), 32'd0);
      chk("st_a_ready_back", 32'(a_ready), 32'd1);
      tick();
      chk("st_a_resume", 32'(Rd), 32'd1);
      a_valid = 1'b0;
      tick();

      // Three back-to-back B with A busy
      a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h2222;
      b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hA0;
      chk("ff_b_ready0", 32'(b_ready), 32'd1);
      tick();
      chk("ff_pend1", 32'(pend_cnt), 32'd1);
      b_rd = 5'd11; b_data = 32'hB1;
      chk("ff_b_ready1", 32'(b_ready), 32'd1);
      tick();
      chk("ff_pend2", 32'(pend_cnt), 32'd2);
      b_rd = 5'd12; b_data = 32'hC2;
      chk("ff_b_ready_full", 32'(b_ready), 32'd0);
      tick();
      chk("ff_pend2_hold", 32'(pend_cnt), 32'd2);
      chk("ff_a_written", 32'(Rd), 32'd2);
      a_valid = 1'b0;
      chk("ff_b_ready_still_full", 32'(b_ready), 32'd0);
      tick();
      chk("ff_out1_rd", 32'(Rd), 32'd10);
      chk("ff_out1_data", data, 32'hA0);
      chk("ff_pend_after1", 32'(pend_cnt), 32'd1);
      chk("ff_b_ready_retry", 32'(b_ready), 32'd1);
      tick();
      b_valid = 1'b0;
      chk("ff_out2_rd", 32'(Rd), 32'd11);
      chk("ff_out2_data", data, 32'hB1);
      chk("ff_pend_enqdeq", 32'(pend_cnt), 32'd1);
      tick();
      chk("ff_out3_rd", 32'(Rd), 32'd12);
      chk("ff_out3_data", data, 32'hC2);
      chk("ff_pend_drained", 32'(pend_cnt), 32'd0);
      tick();

      // rd 0 on both channels is dropped
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hEEEE;
      chk("z_b_ready", 32'(b_ready), 32'd1);
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      chk("z_we", 32'(RegWrite), 32'd0);
      chk("z_pend", 32'(pend_cnt), 32'd0);
      chk("z_rd_hold", 32'(Rd), 32'd12);
      tick();
      chk("z_we2", 32'(RegWrite), 32'd0);
      chk("z_pend2", 32'(pend_cnt), 32'd0);

      // Reset with a full FIFO
      a_valid = 1'b1; a_rd = 5'd8; a_data = 32'h8888;
      b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h4444;
      tick();
      b_rd = 5'd6; b_data = 32'h6666;
      tick();
      chk("rf_pend2", 32'(pend_cnt), 32'd2);
      a_rd = 5'd13; b_valid = 1'b1; b_rd = 5'd14;
      reset = 1'b1;
      tick();
      reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      chk("rf_pend0", 32'(pend_cnt), 32'd0);
      chk("rf_we0", 32'(RegWrite), 32'd0);
      chk("rf_busy0", 32'(busy), 32'd0);
      chk("rf_rd0", 32'(Rd), 32'd0);
      chk("rf_b_ready", 32'(b_ready), 32'd1);
      chk("rf_a_ready", 32'(a_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rf_no_ghost_we", 32'(RegWrite), 32'd0);
         chk("rf_no_ghost_pend", 32'(pend_cnt), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameters: STARVE_LIM, default 4, cycles the B-FIFO head may wait before it takes priority over channel A.
REQ-002 SHALL have ports: clk input 1, sole clock, rising edge.
REQ-003 SHALL have ports: reset input 1, synchronous, active-high.
REQ-004 SHALL have ports: a_valid input 1, channel A (pipeline writeback) write request.
REQ-005 SHALL have ports: a_ready output 1, channel A accepted this cycle when high with a_valid.
REQ-006 SHALL have ports: a_rd input 5, and a_data input 32, channel A destination and value.
REQ-007 SHALL have ports: b_valid input 1, channel B (multi-cycle unit: mult/div/load) write request.
REQ-008 SHALL have ports: b_ready output 1, channel B accepted when high with b_valid.
REQ-009 SHALL have ports: b_rd input 5, and b_data input 32, channel B destination and value.
REQ-010 SHALL have ports: RegWrite output 1, Rd output 5, data output 32, the register-file write port.
REQ-011 SHALL have ports: pend_cnt output 2, occupied B-FIFO entries.
REQ-012 SHALL have ports: busy output 1, high when pend_cnt != 0.

Function
REQ-013 SHALL buffer channel B in a 2-entry FIFO; b_ready = (pend_cnt != 2), evaluated from registered state only.
REQ-014 SHALL ignore b_valid for one cycle when the FIFO is full, with no enqueue, even if the head drains that cycle.
REQ-015 SHALL select at most one write per cycle: if starve_cnt >= STARVE_LIM and FIFO non-empty, select the FIFO head; else if a_valid, select A; else if FIFO non-empty, select the head.
REQ-016 SHALL drive a_ready = 0 only in the cycle the starvation override of REQ-015 applies; otherwise a_ready = 1.
REQ-017 SHALL register the selection: RegWrite/Rd/data SHALL update on the edge after acceptance (latency 1 cycle).
REQ-018 SHALL drop writes with rd = 0: an A request is accepted with RegWrite = 0 next cycle, and a B request is accepted but not enqueued.
REQ-019 SHALL hold Rd/data at their last values when nothing is selected; RegWrite = 0.
REQ-020 SHALL keep starve_cnt (3 bits): 0 when the FIFO is empty or the head is dequeued; otherwise +1 per cycle, saturating at STARVE_LIM.
REQ-021 SHALL allow simultaneous enqueue and dequeue when pend_cnt = 1; FIFO order is preserved and pend_cnt stays at 1.
REQ-022 SHALL provide no ordering guarantee between A and B writes to the same rd; the hazard unit owns that ordering.

Reset
REQ-023 SHALL, on reset, clear RegWrite, Rd, data, pend_cnt, starve_cnt and the FIFO pointers to 0, drop any buffered entries, and set busy=0, b_ready=1, a_ready=1 in the following cycle.
REQ-024 SHALL give reset priority over all same-cycle requests; requests presented during reset are discarded.

Configuration
REQ-025 SHALL, with WB_FWD_EN defined, add inputs fwd_rs, fwd_rt (5 each) and outputs fwd_rs_hit, fwd_rt_hit (1) and fwd_rs_data, fwd_rt_data (32). Each output is a combinational match against the output register (when RegWrite=1), then the newest FIFO entry, then the oldest, in that priority order. rd 0 never hits.
REQ-026 SHALL, without WB_FWD_EN, omit those ports and all matching logic.

Verification
REQ-027 SHALL cover: A only, a_rd=5, a_data=0x1234 -> next cycle RegWrite=1, Rd=5, data=0x1234.
REQ-028 SHALL cover: A and B the same cycle (b_rd=7) -> A written first, B written the next cycle with A idle, pend_cnt 1->0.
REQ-029 SHALL cover: A valid every cycle and one B entry -> B is written on cycle STARVE_LIM+1 after enqueue, a_ready=0 for exactly that cycle.
REQ-030 SHALL cover: three back-to-back B requests with A busy -> b_ready=0 on the third cycle, pend_cnt=2, and no entry is lost.
REQ-031 SHALL cover: a_rd=0 and b_rd=0 -> RegWrite stays 0 and pend_cnt stays 0.
REQ-032 SHALL cover: reset with pend_cnt=2 -> the next cycle shows pend_cnt=0, RegWrite=0, busy=0, and no buffered write ever appears.
